// File: rtl/gate2_selftest_ctrl.sv
// gate2_selftest_ctrl
//   Self-test sequencer for a 2-input combinational gate. A start request walks
//   the four input vectors (a,b) = 00, 01, 10, 11 through the gate. Each vector
//   is held for SETTLE_CYCLES clocks. The gate output is then sampled and
//   compared against the TRUTH table, and a pass/fail verdict, a mismatch count
//   and a per-vector fail map are kept until the next accepted start.
//
//   Parameters
//     SETTLE_CYCLES  clocks spent waiting before the sample cycle (0 = no wait)
//     TRUTH          expected gate output; bit idx is y for a=idx[1], b=idx[0]
//
//   Ports
//     clk        in   rising-edge clock
//     rst_n      in   asynchronous reset, active-low
//     start      in   run request, sampled only while idle
//     dut_y      in   output of the gate under test
//     dut_a      out  gate input a (registered)
//     dut_b      out  gate input b (registered)
//     busy       out  run in progress
//     done       out  run finished; results valid
//     pass       out  1 iff no vector mismatched
//     err_count  out  number of mismatching vectors (0..4)
//     fail_vec   out  bit idx set if vector idx mismatched
module gate2_selftest_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter logic [3:0]  TRUTH         = 4'b1110
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       dut_y,
  output logic       dut_a,
  output logic       dut_b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [3:0] fail_vec
);

  localparam int unsigned CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] WAIT_LAST =
    (SETTLE_CYCLES > 0) ? CNT_W'(SETTLE_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_APPLY,
    S_WAIT,
    S_CHECK
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             dut_a_q, dut_a_d;
  logic             dut_b_q, dut_b_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [2:0]       err_count_q, err_count_d;
  logic [3:0]       fail_vec_q, fail_vec_d;
  logic             mismatch;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      wait_cnt_q  <= '0;
      dut_a_q     <= 1'b0;
      dut_b_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_count_q <= '0;
      fail_vec_q  <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      wait_cnt_q  <= wait_cnt_d;
      dut_a_q     <= dut_a_d;
      dut_b_q     <= dut_b_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      err_count_q <= err_count_d;
      fail_vec_q  <= fail_vec_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    wait_cnt_d  = wait_cnt_q;
    dut_a_d     = dut_a_q;
    dut_b_d     = dut_b_q;
    busy_d      = busy_q;
    done_d      = done_q;
    pass_d      = pass_q;
    err_count_d = err_count_q;
    fail_vec_d  = fail_vec_q;
    // Case inequality so that an X or Z from a broken gate counts as a failure
    // in four-state simulation instead of silently matching.
    mismatch    = (dut_y !== TRUTH[idx_q]);

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_APPLY;
          idx_d       = 2'd0;
          dut_a_d     = 1'b0;
          dut_b_d     = 1'b0;
          busy_d      = 1'b1;
          done_d      = 1'b0;
          pass_d      = 1'b0;
          err_count_d = '0;
          fail_vec_d  = '0;
        end
      end
      S_APPLY: begin
        wait_cnt_d = '0;
        state_d    = (SETTLE_CYCLES > 0) ? S_WAIT : S_CHECK;
      end
      S_WAIT: begin
        if (wait_cnt_q == WAIT_LAST) state_d = S_CHECK;
        else wait_cnt_d = wait_cnt_q + 1'b1;
      end
      S_CHECK: begin
        if (mismatch) begin
          err_count_d        = err_count_q + 3'd1;
          fail_vec_d[idx_q]  = 1'b1;
        end
        if (idx_q == 2'd3) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          // fail_vec_d already includes the final vector's result.
          pass_d  = (fail_vec_d == 4'd0);
        end else begin
          state_d            = S_APPLY;
          idx_d              = idx_q + 2'd1;
          {dut_a_d, dut_b_d} = idx_q + 2'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign dut_a     = dut_a_q;
  assign dut_b     = dut_b_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_count_q;
  assign fail_vec  = fail_vec_q;

endmodule
